// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg
//   Shared types and constants for the count_sequencer block.
//   seq_state_t  : run-controller states
//   bcd_digit_t  : one BCD digit (0..9)
//   DIR_UP/DOWN  : values of the dir input
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } seq_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if
//   Control/display bundle of the count_sequencer.
//   start, stop, clear : single-cycle command pulses (master -> slave)
//   dir                : count direction level, 0 = up, 1 = down
//   tens, units        : BCD display digits (slave -> master)
//   running            : high while counting
//   wrap               : one-cycle pulse when the count wraps
interface count_sequencer_if;
  import count_sequencer_pkg::*;

  logic       start;
  logic       stop;
  logic       clear;
  logic       dir;
  bcd_digit_t tens;
  bcd_digit_t units;
  logic       running;
  logic       wrap;

  modport master (
    output start, stop, clear, dir,
    input  tens, units, running, wrap
  );

  modport slave (
    input  start, stop, clear, dir,
    output tens, units, running, wrap
  );

endinterface

// File: rtl/count_sequencer_tick.sv
// tick_prescaler
//   Divides clk into count steps while enabled.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   enable  : advance the prescaler this cycle
//   restart : force the prescaler back to 0 (wins over enable)
//   step    : high in the cycle whose edge completes a CLK_DIV period
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic step
);

  localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;

  // step is combinational so the count moves on the same edge that
  // returns the prescaler to 0.
  assign step = enable && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= step ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer
//   Run controller plus BCD up/down counter for a two-digit display.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : count_sequencer_if.slave
//         in : start, stop, clear (pulses), dir (0 up, 1 down)
//         out: tens, units (BCD), running, wrap (registered)
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50_000_000,
  parameter int unsigned MAX_COUNT = 63
) (
  input  logic              clk,
  input  logic              rst,
  count_sequencer_if.slave  bus
);

  localparam bcd_digit_t MAX_TENS  = bcd_digit_t'(MAX_COUNT / 10);
  localparam bcd_digit_t MAX_UNITS = bcd_digit_t'(MAX_COUNT % 10);

  seq_state_t r_state, w_state_next;
  bcd_digit_t r_tens, r_units, w_tens_next, w_units_next;
  logic       r_running, r_wrap, w_wrap_next;
  logic       w_enable, w_restart, w_step;

  // Priority clear > stop > start; a stop in any state also masks start.
  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = IDLE;
    end else if (bus.stop) begin
      if (r_state == RUN) w_state_next = PAUSE;
    end else if (bus.start && (r_state != RUN)) begin
      w_state_next = RUN;
    end
  end

  // The prescaler only advances on cycles that stay in RUN, so a stop or
  // clear on a due edge suppresses the step.
  assign w_enable  = (r_state == RUN) && !bus.stop && !bus.clear;
  assign w_restart = bus.clear || (bus.start && !bus.stop && (r_state == IDLE));

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .enable  (w_enable),
    .restart (w_restart),
    .step    (w_step)
  );

  always_comb begin
    w_tens_next  = r_tens;
    w_units_next = r_units;
    w_wrap_next  = 1'b0;
    if (bus.clear) begin
      w_tens_next  = '0;
      w_units_next = '0;
    end else if (w_step) begin
      if (bus.dir == DIR_UP) begin
        if ((r_tens == MAX_TENS) && (r_units == MAX_UNITS)) begin
          w_tens_next  = '0;
          w_units_next = '0;
          w_wrap_next  = 1'b1;
        end else if (r_units == 4'd9) begin
          w_units_next = '0;
          w_tens_next  = r_tens + 4'd1;
        end else begin
          w_units_next = r_units + 4'd1;
        end
      end else begin
        if ((r_tens == 4'd0) && (r_units == 4'd0)) begin
          w_tens_next  = MAX_TENS;
          w_units_next = MAX_UNITS;
          w_wrap_next  = 1'b1;
        end else if (r_units == 4'd0) begin
          w_units_next = 4'd9;
          w_tens_next  = r_tens - 4'd1;
        end else begin
          w_units_next = r_units - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tens    <= '0;
      r_units   <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tens    <= w_tens_next;
      r_units   <= w_units_next;
      r_running <= (w_state_next == RUN);
      r_wrap    <= w_wrap_next;
    end
  end

  assign bus.tens    = r_tens;
  assign bus.units   = r_units;
  assign bus.running = r_running;
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_COUNT = 63;

  logic clk;
  logic rst;

  count_sequencer_if bus ();

  count_sequencer #(
    .CLK_DIV   (CLK_DIV),
    .MAX_COUNT (MAX_COUNT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Behavioural model: binary count, run/pause flags, RUN-cycle phase.
  int m_cnt;
  int m_phase;
  bit m_run;
  bit m_pause;
  bit m_wrap;
  bit m_stepped;

  logic [9:0] gotv;
  assign gotv = {bus.tens, bus.units, bus.running, bus.wrap};

  function automatic logic [9:0] expv();
    return {4'(m_cnt / 10), 4'(m_cnt % 10), logic'(m_run), logic'(m_wrap)};
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_edge(input bit st, input bit sp, input bit cl, input bit d, input bit r);
    m_wrap    = 0;
    m_stepped = 0;
    if (!r) begin
      m_cnt = 0; m_phase = 0; m_run = 0; m_pause = 0;
    end else if (cl) begin
      m_cnt = 0; m_phase = 0; m_run = 0; m_pause = 0;
    end else if (sp) begin
      if (m_run) begin
        m_run = 0; m_pause = 1;
      end
    end else if (m_run) begin
      m_phase++;
      if (m_phase == int'(CLK_DIV)) begin
        m_phase   = 0;
        m_stepped = 1;
        if (!d) begin
          if (m_cnt == int'(MAX_COUNT)) begin m_cnt = 0; m_wrap = 1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = int'(MAX_COUNT); m_wrap = 1; end
          else m_cnt = m_cnt - 1;
        end
      end
    end else if (st) begin
      if (m_pause) begin
        m_pause = 0; m_run = 1;
      end else begin
        m_run = 1; m_phase = 0;
      end
    end
  endtask

  task automatic tick(input bit st, input bit sp, input bit cl, input bit d, input bit r);
    bus.start = st;
    bus.stop  = sp;
    bus.clear = cl;
    bus.dir   = d;
    rst       = r;
    @(posedge clk);
    model_edge(st, sp, cl, d, r);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
    rst       = 1'b1;
  endtask

  // Advance until n model steps have happened (no checking).
  task automatic run_steps(input int n, input bit d);
    int done;
    done = 0;
    for (int c = 0; c < (n + 1) * int'(CLK_DIV) && done < n; c++) begin
      tick(0, 0, 0, d, 1);
      if (m_stepped) done++;
    end
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tests++;
    if (gotv !== 10'd0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", gotv, 10'd0);
    end
  endtask

  task automatic test_count_up();
    tick(1, 0, 0, 0, 1);
    tests++;
    if (bus.running !== 1'b1) begin
      fails++;
      $display("FAIL start_running got=%b exp=1", bus.running);
    end
    for (int i = 0; i < 40; i++) begin
      tick(0, 0, 0, 0, 1);
      tests++;
      if (gotv !== expv()) begin
        fails++;
        $display("FAIL count_up cyc=%0d got=%h exp=%h", i, gotv, expv());
      end
    end
    tests++;
    if ({bus.tens, bus.units} !== 8'h10) begin
      fails++;
      $display("FAIL count_up_40 got=%h exp=10", {bus.tens, bus.units});
    end
  endtask

  task automatic test_wrap_up();
    run_steps(49, 0);
    tests++;
    if ({bus.tens, bus.units} !== 8'h59) begin
      fails++;
      $display("FAIL reach_59 got=%h exp=59", {bus.tens, bus.units});
    end
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < int'(CLK_DIV); c++) begin
        tick(0, 0, 0, 0, 1);
        tests++;
        if (gotv !== expv()) begin
          fails++;
          $display("FAIL wrap_up_cycle got=%h exp=%h", gotv, expv());
        end
        if (m_stepped) break;
      end
      tests++;
      if ({bus.tens, bus.units, bus.wrap} !== {bcd((60 + k) % 64), logic'(k == 4)}) begin
        fails++;
        $display("FAIL wrap_up_step k=%0d got=%h exp=%h", k,
                 {bus.tens, bus.units, bus.wrap}, {bcd((60 + k) % 64), logic'(k == 4)});
      end
    end
    tick(0, 0, 0, 0, 1);
    tests++;
    if (bus.wrap !== 1'b0) begin
      fails++;
      $display("FAIL wrap_one_cycle got=%b exp=0", bus.wrap);
    end
  endtask

  task automatic test_down();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < int'(CLK_DIV); c++) begin
        tick(0, 0, 0, 1, 1);
        tests++;
        if (gotv !== expv()) begin
          fails++;
          $display("FAIL down_cycle got=%h exp=%h", gotv, expv());
        end
        if (m_stepped) break;
      end
      tests++;
      if ({bus.tens, bus.units, bus.wrap} !== {bcd(63 - s), logic'(s == 0)}) begin
        fails++;
        $display("FAIL down_step s=%0d got=%h exp=%h", s,
                 {bus.tens, bus.units, bus.wrap}, {bcd(63 - s), logic'(s == 0)});
      end
    end
    run_steps(52, 1);
    tests++;
    if ({bus.tens, bus.units} !== 8'h10) begin
      fails++;
      $display("FAIL down_reach_10 got=%h exp=10", {bus.tens, bus.units});
    end
    run_steps(1, 1);
    tests++;
    if ({bus.tens, bus.units, bus.wrap} !== {8'h09, 1'b0}) begin
      fails++;
      $display("FAIL down_borrow got=%h exp=090", {bus.tens, bus.units, bus.wrap});
    end
  endtask

  task automatic test_pause();
    int frozen;
    run_steps(1, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 1);
    frozen = m_cnt;
    tests++;
    if (bus.running !== 1'b0) begin
      fails++;
      $display("FAIL stop_running got=%b exp=0", bus.running);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      tests++;
      if (gotv !== {bcd(frozen), 2'b00}) begin
        fails++;
        $display("FAIL pause_hold got=%h exp=%h", gotv, {bcd(frozen), 2'b00});
      end
    end
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tests++;
    if (gotv !== {bcd(frozen), 2'b10}) begin
      fails++;
      $display("FAIL resume_early got=%h exp=%h", gotv, {bcd(frozen), 2'b10});
    end
    tick(0, 0, 0, 0, 1);
    tests++;
    if (gotv !== {bcd((frozen + 1) % 64), 1'b1, logic'(frozen == 63)}) begin
      fails++;
      $display("FAIL resume_step got=%h exp=%h", gotv,
               {bcd((frozen + 1) % 64), 1'b1, logic'(frozen == 63)});
    end
  endtask

  task automatic test_clear_on_step();
    run_steps((63 - m_cnt + 64) % 64, 0);
    for (int c = 0; c < int'(CLK_DIV) && m_phase != int'(CLK_DIV) - 1; c++)
      tick(0, 0, 0, 0, 1);
    tests++;
    if ({bus.tens, bus.units} !== 8'h63) begin
      fails++;
      $display("FAIL clear_setup got=%h exp=63", {bus.tens, bus.units});
    end
    tick(0, 0, 1, 0, 1);
    tests++;
    if (gotv !== 10'd0) begin
      fails++;
      $display("FAIL clear_on_step got=%h exp=000", gotv);
    end
    tick(0, 0, 0, 0, 1);
    tests++;
    if (gotv !== 10'd0) begin
      fails++;
      $display("FAIL clear_idle_hold got=%h exp=000", gotv);
    end
  endtask

  task automatic test_rst_midrun();
    tick(1, 0, 0, 0, 1);
    run_steps(37, 0);
    tests++;
    if (gotv !== {8'h37, 2'b10}) begin
      fails++;
      $display("FAIL rst_setup got=%h exp=%h", gotv, {8'h37, 2'b10});
    end
    tick(0, 0, 0, 0, 0);
    tests++;
    if (gotv !== 10'd0) begin
      fails++;
      $display("FAIL rst_midrun got=%h exp=000", gotv);
    end
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < int'(CLK_DIV); i++) tick(0, 0, 0, 0, 1);
    tests++;
    if (gotv !== {8'h01, 2'b10}) begin
      fails++;
      $display("FAIL rst_restart got=%h exp=%h", gotv, {8'h01, 2'b10});
    end
  endtask

  task automatic test_random();
    bit d;
    d = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) d = ~d;
      tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 59) == 0), d, 1'($urandom_range(0, 199) != 0));
      tests++;
      if (gotv !== expv()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, gotv, expv());
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    m_cnt = 0; m_phase = 0; m_run = 0; m_pause = 0; m_wrap = 0; m_stepped = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0; bus.dir = 1'b0;
    test_reset();
    test_count_up();
    test_wrap_up();
    test_down();
    test_pause();
    test_clear_on_step();
    test_rst_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run-control and timebase block for the two-digit seven-segment counter display. It converts start/stop/clear button pulses into a three-state run controller and divides the board clock into count steps. It maintains a BCD count from 0 to MAX_COUNT, counting up or down with wrap-around. Its tens/units digits drive the seven-segment decoder stage directly.

## Interface
Parameters:
- CLK_DIV, default 50_000_000: clock cycles spent in RUN per count step; legal range ≥ 2.
- MAX_COUNT, default 63: highest count value; legal range 1..99. The count wraps between MAX_COUNT and 0.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-low (rst = 0 resets on the next rising edge of clk).
- start  in  1  single-cycle pulse; enter or resume counting.
- stop  in  1  single-cycle pulse; pause counting and hold the value.
- clear  in  1  single-cycle pulse; return to IDLE with count 0.
- dir  in  1  direction: 0 = up, 1 = down. Level signal, sampled at each step.
- tens  out  4  BCD tens digit, 0..9.
- units  out  4  BCD units digit, 0..9.
- running  out  1  high while the state is RUN.
- wrap  out  1  one-cycle pulse on the edge where the count wraps.

## Operation
- States:
  - IDLE: count is 0 and the prescaler is 0.
  - RUN: the prescaler advances one per clock cycle.
  - PAUSE: the count and the prescaler both hold.
- Transitions, in priority order clear > stop > start:
  - clear from any state → IDLE; count = 0, prescaler = 0.
  - stop in RUN → PAUSE. stop in IDLE or PAUSE is ignored.
  - start in IDLE → RUN, with prescaler = 0.
  - start in PAUSE → RUN; the prescaler resumes from its held value.
  - start in RUN is ignored.
- Prescaler:
  - Counts 0..CLK_DIV-1 in RUN only.
  - When it reaches CLK_DIV-1, an internal step pulse fires and the prescaler returns to 0.
  - Its width is $clog2(CLK_DIV).
- Step with dir=0 (up):
  - If count == MAX_COUNT: count → 0 and wrap = 1.
  - Otherwise the units digit increments. If units == 9, units → 0 and tens increments.
- Step with dir=1 (down):
  - If count == 0: count → MAX_COUNT (tens = MAX_COUNT/10, units = MAX_COUNT%10) and wrap = 1.
  - Otherwise the units digit decrements. If units == 0, units → 9 and tens decrements.
- The count is always valid BCD and never exceeds MAX_COUNT. No binary-to-BCD conversion is performed.

## Timing
- All outputs are registered and change only on rising edges.
- Reset values: state IDLE, tens 0, units 0, running 0, wrap 0, prescaler 0.
- rst low overrides every other input, including in mid-run.
- A start sampled at edge N gives state RUN and running = 1 after edge N.
- The first step lands on edge N+CLK_DIV; later steps follow every CLK_DIV cycles of RUN.
- A stop sampled at edge M:
  - running = 0 after edge M.
  - If a step was due at edge M, stop wins: no count change and no wrap.
- clear in the same cycle as a due step: clear wins, the count becomes 0, wrap = 0.
- wrap is high for exactly the one cycle after the wrapping edge.
- A dir change takes effect at the next step; the prescaler phase is not disturbed.
- Simultaneous start and stop: stop wins. From IDLE, the state stays IDLE.

## Structure
- Package count_sequencer_pkg holds:
  - typedef enum logic [1:0] seq_state_t {IDLE, RUN, PAUSE};
  - typedef logic [3:0] bcd_digit_t;
  - the direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- One sub-module, tick_prescaler. Parameter CLK_DIV. Inputs: clk, rst, enable, restart. Output: step.
- Everything else lives in count_sequencer: the state register, the BCD up/down counter and the output registers.

## Test plan
All scenarios use CLK_DIV=4, MAX_COUNT=63.
- Reset then start, dir=0, 40 cycles in RUN → count 10 (tens=1, units=0). running = 1 from the edge after start.
- Count up from 59 for 4 steps → 60, 61, 62, 63. The next step gives 0 with a one-cycle wrap pulse.
- dir=1 from count 0, one step → tens=6, units=3 and wrap=1. Next step → 62. From 10, a step → 09.
- Stop after 2 cycles of a prescaler period, wait 20 cycles, then start → count frozen during PAUSE. The next step lands exactly 2 cycles after resume.
- clear asserted on a step edge while at 63, dir=0 → count 0, wrap stays 0, state IDLE.
- rst=0 for one edge while RUN at count 37 → all outputs at reset values. start then counts again from 0.
